// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg
//   Shared definitions for the PLL reset sequencer: the sequencer state
//   encoding, the saturation limit of the event counters, and the helper that
//   sizes the shared timing counter from the timing parameters.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,  // PLL held in reset
    WAIT_LOCK = 3'd1,  // PLL running, waiting for synced lock
    STABLE    = 3'd2,  // lock seen, proving it stays up
    RELEASE   = 3'd3,  // domain resets being dropped in index order
    RUN       = 3'd4   // all domains out of reset
  } seq_state_e;

  localparam logic [7:0] EVT_CNT_MAX = 8'hFF;

  // The shared counter must reach every terminal count used by the sequencer.
  // The release span (stagger times domain count) is passed in alongside the
  // plain timing parameters because it can exceed any one of them.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a slow asynchronous status bit (PLL lock and
//   similar CDC status signals). Adds two clocks of latency.
// Ports
//   clk  in  destination clock
//   rst  in  synchronous active-high reset, forces both stages to RST_VAL
//   d_i  in  asynchronous input bit
//   q_o  out synchronized bit
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make the two stages shift one bit per clock;
  // blocking ones would collapse them into a single flop and defeat the synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq
//   Reset sequencer sitting right after the PLL, clocked by the PLL reference
//   clock. Pulses the PLL reset, waits for lock, requires lock to stay up for
//   STABLE_CYCLES clocks, then releases the domain resets one by one,
//   STAGGER_CYCLES apart. A lock timeout retries the PLL; a lock loss after
//   release began re-asserts every domain reset, is counted and flagged, and
//   restarts the PLL.
// Ports
//   clk        in   reference clock
//   rst        in   synchronous active-high reset
//   lock       in   PLL lock, asynchronous to clk
//   clr_lost   in   one-cycle pulse clearing lock_lost
//   pll_rst    out  reset to the PLL
//   sys_rst    out  active-high per-domain resets, released in index order
//   ready      out  all domains released and lock present
//   lock_lost  out  sticky lock-loss flag
//   loss_cnt   out  lock-loss events, saturating at 255
//   retry_cnt  out  PLL retries after a lock timeout, saturating at 255
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int NUM_DOMAINS    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 256,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lock,
  input  logic                   clr_lost,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] sys_rst,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [7:0]             loss_cnt,
  output logic [7:0]             retry_cnt
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                STAGGER_CYCLES * NUM_DOMAINS);

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK edge that first sees lock counts as the first stable clock,
  // so STABLE itself only has STABLE_CYCLES-1 more clocks to wait.
  localparam logic [CW-1:0] STABLE_LAST  = CW'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
  // A single domain still spends one clock in RELEASE before ready rises.
  localparam logic [CW-1:0] RELEASE_LAST = CW'((NUM_DOMAINS == 1) ? 1
                                              : STAGGER_CYCLES * (NUM_DOMAINS - 1));

  logic                   lock_s;
  seq_state_e             state_q,     state_d;
  logic [CW-1:0]          cnt_q,       cnt_d;
  logic [CW-1:0]          cnt_inc;
  logic                   pll_rst_q,   pll_rst_d;
  logic [NUM_DOMAINS-1:0] sys_rst_q,   sys_rst_d;
  logic                   ready_q,     ready_d;
  logic                   lock_lost_q, lock_lost_d;
  logic [7:0]             loss_cnt_q,  loss_cnt_d;
  logic [7:0]             retry_cnt_q, retry_cnt_d;
  logic                   loss_evt;

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (lock),
    .q_o (lock_s)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    // NOTE: every next-state value starts as its hold value, so no path through
    // the case statement leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pll_rst_d   = pll_rst_q;
    sys_rst_d   = sys_rst_q;
    ready_d     = ready_q;
    loss_cnt_d  = loss_cnt_q;
    retry_cnt_d = retry_cnt_q;
    loss_evt    = 1'b0;

    unique case (state_q)
      PLL_RST: begin
        pll_rst_d = 1'b1;
        if (cnt_q == PLL_RST_LAST) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_LOCK: begin
        pll_rst_d = 1'b0;
        if (lock_s) begin
          cnt_d = '0;
          if (STABLE_CYCLES == 1) begin
            state_d      = RELEASE;
            sys_rst_d[0] = 1'b0;
          end else begin
            state_d = STABLE;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = PLL_RST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          if (retry_cnt_q != EVT_CNT_MAX) retry_cnt_d = retry_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      STABLE: begin
        if (!lock_s) begin
          // A dropout before release only restarts the timeout; not a retry.
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d      = RELEASE;
          cnt_d        = '0;
          sys_rst_d[0] = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RELEASE, RUN: begin
        if (!lock_s) begin
          loss_evt  = 1'b1;
          state_d   = PLL_RST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          sys_rst_d = '1;
          ready_d   = 1'b0;
          if (loss_cnt_q != EVT_CNT_MAX) loss_cnt_d = loss_cnt_q + 8'd1;
        end else if (state_q == RELEASE) begin
          // cnt counts clocks since sys_rst[0] dropped.
          cnt_d = cnt_inc;
          for (int i = 1; i < NUM_DOMAINS; i++) begin
            if (cnt_inc == CW'(STAGGER_CYCLES * i)) sys_rst_d[i] = 1'b0;
          end
          if (cnt_inc == RELEASE_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = PLL_RST;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
        sys_rst_d = '1;
        ready_d   = 1'b0;
      end
    endcase

    // A loss on the same clock as a clear keeps the flag set.
    if (loss_evt)      lock_lost_d = 1'b1;
    else if (clr_lost) lock_lost_d = 1'b0;
    else               lock_lost_d = lock_lost_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= '1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign loss_cnt  = loss_cnt_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq
//   Self-checking bench for pll_rst_seq with short timing parameters.
//   Hand-derived vector table for the nominal bring-up, hand-written
//   sequences for retry, glitch, loss, clear, saturation and mid-release
//   reset, then random lock/clear/reset traffic against a streak-based model.
module tb_pll_rst_seq;

  localparam int ND  = 2;
  localparam int PRC = 4;
  localparam int LT  = 32;
  localparam int SC  = 8;
  localparam int SG  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          lock;
  logic          clr_lost;
  logic          pll_rst;
  logic [ND-1:0] sys_rst;
  logic          ready;
  logic          lock_lost;
  logic [7:0]    loss_cnt;
  logic [7:0]    retry_cnt;

  int total = 0;
  int bad   = 0;

  pll_rst_seq #(
    .NUM_DOMAINS    (ND),
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC),
    .STAGGER_CYCLES (SG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lock      (lock),
    .clr_lost  (clr_lost),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .lock_lost (lock_lost),
    .loss_cnt  (loss_cnt),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, return on the following falling edge.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Reference model. The PLL is either in a reset pulse (rst_left clocks
  // remaining) or not; outside a pulse the only state that matters is how
  // long synced lock has been continuously present (streak) and how long it
  // has been absent while waiting (wait). Domain i is out of reset once the
  // streak reaches SC + SG*i.
  // ---------------------------------------------------------------------
  logic m_d1, m_d2;
  int   m_rst_left, m_wait, m_streak, m_loss, m_retry;
  logic m_lost;

  task automatic model_step();
    logic ls;
    logic loss;
    ls   = m_d2;
    m_d2 = m_d1;
    m_d1 = lock;
    loss = 1'b0;
    if (rst) begin
      m_d1 = 1'b0; m_d2 = 1'b0;
      m_rst_left = PRC; m_wait = 0; m_streak = 0;
      m_loss = 0; m_retry = 0; m_lost = 1'b0;
    end else begin
      if (m_rst_left > 0) begin
        m_rst_left--;
      end else if (ls) begin
        m_streak++;
      end else if (m_streak >= SC) begin
        loss = 1'b1;
        if (m_loss < 255) m_loss++;
        m_rst_left = PRC; m_streak = 0; m_wait = 0;
      end else if (m_streak > 0) begin
        m_streak = 0; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == LT) begin
          if (m_retry < 255) m_retry++;
          m_rst_left = PRC; m_wait = 0;
        end
      end
      if (loss)          m_lost = 1'b1;
      else if (clr_lost) m_lost = 1'b0;
    end
  endtask

  function automatic logic [20:0] model_out();
    logic [ND-1:0] s;
    logic          p, r;
    p = (m_rst_left > 0);
    for (int i = 0; i < ND; i++) s[i] = !(m_rst_left == 0 && m_streak >= SC + SG * i);
    r = (m_rst_left == 0 && m_streak >= SC + SG * (ND - 1));
    return {p, s, r, m_lost, 8'(m_loss), 8'(m_retry)};
  endfunction

  task automatic rstep();
    logic [20:0] act_v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    act_v = {pll_rst, sys_rst, ready, lock_lost, loss_cnt, retry_cnt};
    check("model", 32'(act_v), 32'(model_out()));
  endtask

  typedef struct {
    logic       lk;
    logic       clr;
    logic       rs;
    int         cyc;
    logic       pll;
    logic [1:0] sys;
    logic       rdy;
    logic       lost;
    logic [7:0] loss;
    logic [7:0] retry;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int   rises[$];
    int   odd;
    logic prev;
    int   seg_left;

    rst = 1'b1; lock = 1'b0; clr_lost = 1'b0;

    // Nominal bring-up: pll_rst high 4 clocks, lock rises 10 clocks after it
    // falls, sys_rst[0] falls 10 clocks after lock, sys_rst[1] and ready 2 later.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1,  1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 9,  1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 9,  1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 2'b10, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 2'b10, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 2'b00, 1'b1, 1'b0, 8'd0, 8'd0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 20, 1'b0, 2'b00, 1'b1, 1'b0, 8'd0, 8'd0};

    for (int v = 0; v < 9; v++) begin
      lock     = vecs[v].lk;
      clr_lost = vecs[v].clr;
      rst      = vecs[v].rs;
      clk_n(vecs[v].cyc);
      check($sformatf("vec%0d_pll_rst", v),   32'(pll_rst),   32'(vecs[v].pll));
      check($sformatf("vec%0d_sys_rst", v),   32'(sys_rst),   32'(vecs[v].sys));
      check($sformatf("vec%0d_ready", v),     32'(ready),     32'(vecs[v].rdy));
      check($sformatf("vec%0d_lock_lost", v), 32'(lock_lost), 32'(vecs[v].lost));
      check($sformatf("vec%0d_loss_cnt", v),  32'(loss_cnt),  32'(vecs[v].loss));
      check($sformatf("vec%0d_retry_cnt", v), 32'(retry_cnt), 32'(vecs[v].retry));
    end
    rst = 1'b0; clr_lost = 1'b0;

    // Lock never comes: pll_rst re-pulses every 36 clocks, retry_cnt 1,2,3.
    lock = 1'b0;
    do_rst();
    prev = 1'b1;
    odd  = 0;
    for (int e = 1; e <= 110; e++) begin
      clk_n(1);
      if (pll_rst && !prev) rises.push_back(e);
      prev = pll_rst;
      if (sys_rst != 2'b11 || ready) odd++;
      if (e % 36 == 0) check($sformatf("retry_cnt_at_%0d", e), 32'(retry_cnt), 32'(e / 36));
    end
    check("retry_pulse_count", 32'(rises.size()), 32'd3);
    for (int k = 0; k < rises.size(); k++)
      check($sformatf("retry_pulse%0d_edge", k), 32'(rises[k]), 32'(36 * (k + 1)));
    check("retry_resets_held", 32'(odd), 32'd0);

    // Glitch: one low clock after 5 stable clocks restarts the stable window.
    lock = 1'b0;
    do_rst();                        // E0
    clk_n(4);                        // E4
    check("glitch_pll_fall", 32'(pll_rst), 32'd0);
    lock = 1'b1; clk_n(5);           // E9
    lock = 1'b0; clk_n(1);           // E10
    lock = 1'b1; clk_n(4);           // E14: unglitched release point
    check("glitch_no_early_release", 32'(sys_rst), 32'b11);
    clk_n(5);                        // E19
    check("glitch_pre_release", 32'(sys_rst), 32'b11);
    clk_n(1);                        // E20
    check("glitch_release", 32'(sys_rst), 32'b10);
    check("glitch_retry_cnt", 32'(retry_cnt), 32'd0);
    clk_n(2);                        // E22
    check("glitch_run_sys", 32'(sys_rst), 32'b00);
    check("glitch_run_ready", 32'(ready), 32'd1);

    // Loss in RUN: all resets back within 3 clocks, PLL pulsed, relock repeats.
    clk_n(3);                        // E25
    lock = 1'b0; clk_n(2);           // E27
    check("loss_not_yet", 32'(sys_rst), 32'b00);
    clk_n(1);                        // E28
    check("loss_sys_rst", 32'(sys_rst), 32'b11);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_flag", 32'(lock_lost), 32'd1);
    check("loss_cnt_1", 32'(loss_cnt), 32'd1);
    check("loss_pll_rst", 32'(pll_rst), 32'd1);
    clk_n(3);                        // E31
    check("loss_pll_hold", 32'(pll_rst), 32'd1);
    clk_n(1);                        // E32
    check("loss_pll_fall", 32'(pll_rst), 32'd0);
    lock = 1'b1; clk_n(9);           // E41
    check("relock_pre", 32'(sys_rst), 32'b11);
    clk_n(1);                        // E42
    check("relock_rel0", 32'(sys_rst), 32'b10);
    clk_n(2);                        // E44
    check("relock_run", 32'({sys_rst, ready, lock_lost, loss_cnt}), 32'({2'b00, 1'b1, 1'b1, 8'd1}));

    // Clear coinciding with a second loss: loss wins. Clear alone later clears.
    clk_n(2);                        // E46
    lock = 1'b0; clk_n(2);           // E48
    clr_lost = 1'b1; clk_n(1);       // E49
    clr_lost = 1'b0;
    check("clr_vs_loss_flag", 32'(lock_lost), 32'd1);
    check("clr_vs_loss_cnt", 32'(loss_cnt), 32'd2);
    clk_n(1);
    clr_lost = 1'b1; clk_n(1);
    clr_lost = 1'b0;
    check("clr_alone", 32'(lock_lost), 32'd0);

    // 300 forced losses: 12 clocks of lock reaches release, 3 clocks low loses it.
    lock = 1'b0;
    do_rst();
    for (int k = 1; k <= 300; k++) begin
      lock = 1'b1; clk_n(12);
      if (k == 1) check("sat_first_release", 32'(sys_rst), 32'b10);
      lock = 1'b0; clk_n(3);
      if (k == 1 || k == 255 || k == 300)
        check($sformatf("sat_loss_cnt_%0d", k), 32'(loss_cnt), 32'((k > 255) ? 255 : k));
    end
    check("sat_flag", 32'(lock_lost), 32'd1);

    // Reset while mid-release clears everything on that edge and restarts.
    lock = 1'b1; clk_n(12);
    check("midrel_sys_rst", 32'(sys_rst), 32'b10);
    rst = 1'b1; clk_n(1);
    rst = 1'b0;
    check("midrel_rst_outputs",
          32'({pll_rst, sys_rst, ready, lock_lost, loss_cnt, retry_cnt}),
          32'({1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 8'd0}));
    clk_n(11);
    check("midrel_restart_pre", 32'(sys_rst), 32'b11);
    clk_n(1);
    check("midrel_restart_rel0", 32'(sys_rst), 32'b10);
    clk_n(2);
    check("midrel_restart_ready", 32'({sys_rst, ready}), 32'({2'b00, 1'b1}));

    // Random lock segments, clears and rare resets against the model.
    lock = 1'b0; clr_lost = 1'b0; rst = 1'b1;
    rstep();
    rst = 1'b0;
    seg_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seg_left == 0) begin
        lock     = 1'($urandom_range(0, 1));
        seg_left = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(5, 60));
      end
      seg_left--;
      clr_lost = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      rstep();
    end
    rst = 1'b0; clr_lost = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
